// File: rtl/pipeline_controller_pkg.sv
// Shared LC-3b pipeline types: opcode encoding, controller state, control-op test.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package pipeline_controller_pkg;

    typedef enum logic [3:0] {
        op_br   = 4'b0000,
        op_add  = 4'b0001,
        op_ldb  = 4'b0010,
        op_stb  = 4'b0011,
        op_jsr  = 4'b0100,
        op_and  = 4'b0101,
        op_ldw  = 4'b0110,
        op_stw  = 4'b0111,
        op_rti  = 4'b1000,
        op_xor  = 4'b1001,
        op_rsva = 4'b1010,
        op_rsvb = 4'b1011,
        op_jmp  = 4'b1100,
        op_shf  = 4'b1101,
        op_lea  = 4'b1110,
        op_trap = 4'b1111
    } lc3b_opcode;

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        LU_STALL  = 2'd1,
        CTRL_WAIT = 2'd2
    } pipe_ctrl_state_t;

    localparam logic [3:0] WAIT_CNT_MAX = 4'hF;

    // Opcodes that redirect the PC once they resolve in MEM.
    function automatic logic is_ctrl_op(input lc3b_opcode op);
        return (op == op_br) || (op == op_jmp) || (op == op_jsr) || (op == op_trap);
    endfunction

endpackage

// File: rtl/pipeline_controller_if.sv
// Bundle of hazard/handshake inputs and stage-enable outputs of the pipeline controller.
// Latency: n/a (wires only).
// Backpressure: n/a; master = pipeline datapath, slave = controller.
interface pipeline_controller_if
    import pipeline_controller_pkg::*;
#(
    parameter int STALL_CNT_W = 16
) ();
    // pipeline -> controller
    logic        id_valid;
    lc3b_opcode  id_opcode;
    logic        id_is_nop;
    logic        load_use_hazard;
    logic        mem_ctrl_resolve;
    logic        if_mem_req;
    logic        imem_resp;
    logic        dmem_req;
    logic        dmem_resp;
    // controller -> pipeline
    logic        load_pc;
    logic        load_if_id;
    logic        load_id_ex;
    logic        load_ex_mem;
    logic        load_mem_wb;
    logic        bubble_id_ex;
    logic        flush_if_id;
    logic        ctrl_pending;
    logic        ctrl_timeout;
    logic [STALL_CNT_W-1:0] stall_cycles;

    modport master (
        output id_valid, id_opcode, id_is_nop, load_use_hazard, mem_ctrl_resolve,
               if_mem_req, imem_resp, dmem_req, dmem_resp,
        input  load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb,
               bubble_id_ex, flush_if_id, ctrl_pending, ctrl_timeout, stall_cycles
    );

    modport slave (
        input  id_valid, id_opcode, id_is_nop, load_use_hazard, mem_ctrl_resolve,
               if_mem_req, imem_resp, dmem_req, dmem_resp,
        output load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb,
               bubble_id_ex, flush_if_id, ctrl_pending, ctrl_timeout, stall_cycles
    );

endinterface

// File: rtl/pipeline_controller_sat_counter.sv
// Saturating up-counter with enable and asynchronous active-low clear.
// Latency: count visible the cycle after an enabled edge.
// Backpressure: none; holds at all-ones instead of wrapping.
// Ports: clk, clr_n (async clear), en (count this cycle), cnt (current value).
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         clr_n,
    input  logic         en,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            cnt <= '0;
        end else if (en && (cnt != {W{1'b1}})) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/pipeline_controller.sv
// Stall/flush sequencer for the 5-stage LC-3b pipeline plus stall counter and timeout flag.
// Latency: enables are combinational from state and current-cycle inputs (no output register).
// Backpressure: a pending data access freezes every stage; IF waits flush IF/ID.
// Ports: clk, rst_n (async active-low), pif (slave side of pipeline_controller_if).
module pipeline_controller
    import pipeline_controller_pkg::*;
#(
    parameter int CTRL_TIMEOUT = 8,
    parameter int STALL_CNT_W  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    pipeline_controller_if.slave  pif
);

    localparam logic [3:0] TIMEOUT_CNT = 4'(CTRL_TIMEOUT);

    pipe_ctrl_state_t state, state_nxt;
    logic [3:0]       wait_cnt, wait_cnt_nxt;
    logic             timeout_q, timeout_nxt;

    logic is_ctrl;
    logic freeze;
    logic fetch_wait;
    logic hazard;

    logic ld_pc, ld_if_id, ld_id_ex, ld_ex_mem, ld_mem_wb;
    logic bubble, flush;

    // A BR with nzp=000 never redirects, so it flows like any ALU op.
    assign is_ctrl    = pif.id_valid & is_ctrl_op(pif.id_opcode)
                      & ~((pif.id_opcode == op_br) & pif.id_is_nop);
    assign freeze     = pif.dmem_req & ~pif.dmem_resp;
    assign fetch_wait = pif.if_mem_req & ~pif.imem_resp;
    assign hazard     = pif.id_valid & pif.load_use_hazard;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= RUN;
            wait_cnt  <= 4'd0;
            timeout_q <= 1'b0;
        end else begin
            state     <= state_nxt;
            wait_cnt  <= wait_cnt_nxt;
            timeout_q <= timeout_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        timeout_nxt  = timeout_q;
        ld_pc        = 1'b1;
        ld_if_id     = 1'b1;
        ld_id_ex     = 1'b1;
        ld_ex_mem    = 1'b1;
        ld_mem_wb    = 1'b1;
        bubble       = 1'b0;
        flush        = 1'b0;

        if (freeze) begin
            // Whole pipe holds; state and wait counter are untouched.
            ld_pc     = 1'b0;
            ld_if_id  = 1'b0;
            ld_id_ex  = 1'b0;
            ld_ex_mem = 1'b0;
            ld_mem_wb = 1'b0;
        end else begin
            case (state)
                RUN, LU_STALL: begin
                    state_nxt = RUN;
                    // The instruction held in LU_STALL already paid its bubble,
                    // so the hazard flag is ignored there.
                    if ((state == RUN) && hazard) begin
                        ld_pc     = 1'b0;
                        ld_if_id  = 1'b0;
                        bubble    = 1'b1;
                        state_nxt = LU_STALL;
                    end else if (is_ctrl) begin
                        ld_pc        = 1'b0;
                        flush        = 1'b1;
                        wait_cnt_nxt = 4'd0;
                        state_nxt    = CTRL_WAIT;
                    end else if (fetch_wait) begin
                        ld_pc = 1'b0;
                        flush = 1'b1;
                    end
                end
                CTRL_WAIT: begin
                    // Slot behind the control op is always squashed, including
                    // the resolve cycle; the PC takes the target on resolve.
                    ld_pc = pif.mem_ctrl_resolve;
                    flush = 1'b1;
                    if (wait_cnt != WAIT_CNT_MAX) begin
                        wait_cnt_nxt = wait_cnt + 4'd1;
                    end
                    if (pif.mem_ctrl_resolve) begin
                        state_nxt = RUN;
                    end else if (wait_cnt_nxt >= TIMEOUT_CNT) begin
                        timeout_nxt = 1'b1;
                    end
                end
                default: begin
                    state_nxt = RUN;
                end
            endcase
        end
    end

    sat_counter #(
        .W (STALL_CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .clr_n (rst_n),
        .en    (~ld_pc),
        .cnt   (pif.stall_cycles)
    );

    // Enables are forced low while reset is held so nothing downstream loads.
    assign pif.load_pc      = rst_n & ld_pc;
    assign pif.load_if_id   = rst_n & ld_if_id;
    assign pif.load_id_ex   = rst_n & ld_id_ex;
    assign pif.load_ex_mem  = rst_n & ld_ex_mem;
    assign pif.load_mem_wb  = rst_n & ld_mem_wb;
    assign pif.bubble_id_ex = rst_n & bubble;
    assign pif.flush_if_id  = rst_n & flush;
    assign pif.ctrl_pending = rst_n & (state == CTRL_WAIT);
    assign pif.ctrl_timeout = rst_n & timeout_q;

endmodule

// File: tb/tb_pipeline_controller.sv
// Bench for pipeline_controller: directed scenarios plus randomized traffic against a reference model.
// Latency: compares each cycle 2 time units after inputs change.
// Backpressure: models freeze, imem wait and control wait behaviour.
module tb_pipeline_controller;
    import pipeline_controller_pkg::*;

    localparam int SCW  = 6;
    localparam int TMO  = 8;
    localparam int SMAX = (1 << SCW) - 1;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    pipeline_controller_if #(.STALL_CNT_W(SCW)) pif ();

    pipeline_controller #(
        .CTRL_TIMEOUT (TMO),
        .STALL_CNT_W  (SCW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .pif   (pif)
    );

    typedef struct packed {
        logic lpc, lifid, lidex, lexm, lmwb, bub, flush, pend, tmo;
        logic [SCW-1:0] st;
    } obs_t;

    int   checks = 0;
    int   errors = 0;
    obs_t got, exp_o;

    // Reference model: what the pipeline is doing, in plain terms.
    bit m_lu;      // previous cycle inserted a load-use bubble
    bit m_wait;    // a control op left ID and has not resolved yet
    bit m_tmo;
    int m_unres;   // unresolved, unfrozen cycles spent waiting
    int m_stall;   // cycles where the PC did not advance

    function automatic void model_reset();
        m_lu = 0; m_wait = 0; m_tmo = 0; m_unres = 0; m_stall = 0;
    endfunction

    function automatic bit model_ctrl();
        logic [3:0] op;
        op = pif.id_opcode;
        return pif.id_valid && ((op == 4'h0 && !pif.id_is_nop) || op == 4'h4 ||
                                op == 4'hC || op == 4'hF);
    endfunction

    function automatic obs_t predict();
        obs_t e;
        e = '0;
        if (!rst_n) return e;
        e.pend = m_wait;
        e.tmo  = m_tmo;
        e.st   = SCW'(m_stall);
        if (!(pif.dmem_req && !pif.dmem_resp)) begin
            {e.lpc, e.lifid, e.lidex, e.lexm, e.lmwb} = 5'b11111;
            if (m_wait) begin
                e.lpc = pif.mem_ctrl_resolve;
                e.flush = 1'b1;
            end else if (!m_lu && pif.id_valid && pif.load_use_hazard) begin
                e.lpc = 1'b0; e.lifid = 1'b0; e.bub = 1'b1;
            end else if (model_ctrl() || (pif.if_mem_req && !pif.imem_resp)) begin
                e.lpc = 1'b0; e.flush = 1'b1;
            end
        end
        return e;
    endfunction

    function automatic void model_update(input obs_t e);
        bit frz;
        frz = pif.dmem_req && !pif.dmem_resp;
        if (!e.lpc && m_stall < SMAX) m_stall++;
        if (!frz) begin
            if (m_wait) begin
                if (pif.mem_ctrl_resolve) begin
                    m_wait = 0;
                end else begin
                    m_unres++;
                    if (m_unres >= TMO) m_tmo = 1;
                end
            end else if (!m_lu && pif.id_valid && pif.load_use_hazard) begin
                m_lu = 1;
            end else begin
                m_lu = 0;
                if (model_ctrl()) begin
                    m_wait = 1;
                    m_unres = 0;
                end
            end
        end
    endfunction

    function automatic obs_t sample();
        obs_t o;
        o.lpc = pif.load_pc;       o.lifid = pif.load_if_id;  o.lidex = pif.load_id_ex;
        o.lexm = pif.load_ex_mem;  o.lmwb = pif.load_mem_wb;  o.bub = pif.bubble_id_ex;
        o.flush = pif.flush_if_id; o.pend = pif.ctrl_pending; o.tmo = pif.ctrl_timeout;
        o.st = pif.stall_cycles;
        return o;
    endfunction

    task automatic chk1(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    // One pipeline cycle: drive, compare against the model, advance the model, cross the edge.
    task automatic step(input bit v, input lc3b_opcode op, input bit nop, input bit luh,
                        input bit res, input bit ireq, input bit iresp,
                        input bit dreq, input bit dresp);
        pif.id_valid = v;          pif.id_opcode = op;      pif.id_is_nop = nop;
        pif.load_use_hazard = luh; pif.mem_ctrl_resolve = res;
        pif.if_mem_req = ireq;     pif.imem_resp = iresp;
        pif.dmem_req = dreq;       pif.dmem_resp = dresp;
        #2;
        got   = sample();
        exp_o = predict();
        checks++;
        if (got !== exp_o) begin
            errors++;
            $display("FAIL cycle_outputs got %h expected %h at %0t", got, exp_o, $time);
        end
        model_update(exp_o);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input bit res);
        step(1'b0, op_add, 1'b0, 1'b0, res, 1'b1, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        #1 got = sample();
        chk1("async_reset_outputs_zero", int'(got), 0);
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        pif.id_valid = 0; pif.id_opcode = op_add; pif.id_is_nop = 0;
        pif.load_use_hazard = 0; pif.mem_ctrl_resolve = 0;
        pif.if_mem_req = 0; pif.imem_resp = 1; pif.dmem_req = 0; pif.dmem_resp = 0;
        model_reset();
        #1 rst_n = 1'b0;
        #2 got = sample();
        chk1("reset_outputs_zero", int'(got), 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // ADD stream with instant fetches: nothing ever stalls.
        repeat (5) step(1, op_add, 0, 0, 0, 1, 1, 0, 0);
        chk1("add_stream_loads", int'({got.lpc, got.lifid, got.lidex, got.lexm, got.lmwb}), 'b11111);
        chk1("add_stream_stall_cnt", int'(got.st), 0);

        // LDW then dependent ADD: one bubble, then the ADD advances.
        step(1, op_ldw, 0, 0, 0, 1, 1, 0, 0);
        step(1, op_add, 0, 1, 0, 1, 1, 0, 0);
        chk1("lu_bubble", int'({got.lpc, got.lifid, got.bub, got.lidex}), 'b0011);
        step(1, op_add, 0, 0, 0, 1, 1, 0, 0);
        chk1("lu_release", int'({got.lpc, got.lifid, got.bub}), 'b110);
        chk1("lu_stall_cnt", int'(got.st), 1);

        // Taken BR resolving two cycles later.
        step(1, op_br, 0, 0, 0, 1, 1, 0, 0);
        chk1("br_t0", int'({got.flush, got.lpc, got.pend}), 'b100);
        idle(0);
        chk1("br_t1", int'({got.flush, got.lpc, got.pend}), 'b101);
        idle(1);
        chk1("br_t2_resolve", int'({got.flush, got.lpc, got.pend}), 'b111);
        step(1, op_add, 0, 0, 0, 1, 1, 0, 0);
        chk1("br_t3_run", int'({got.flush, got.lpc, got.pend}), 'b010);
        chk1("br_stall_cnt", int'(got.st), 3);

        // BR with nzp=000 is not a control transfer.
        step(1, op_br, 1, 0, 0, 1, 1, 0, 0);
        chk1("br_nop_no_flush", int'({got.flush, got.lpc}), 'b01);

        // JMP with a 3-cycle data freeze inside the wait; resolve during freeze is ignored.
        step(1, op_jmp, 0, 0, 0, 1, 1, 0, 0);
        idle(0);
        repeat (3) step(0, op_add, 0, 0, 1, 1, 1, 1, 0);
        chk1("freeze_all_loads_zero",
             int'({got.lpc, got.lifid, got.lidex, got.lexm, got.lmwb, got.bub, got.flush}), 0);
        chk1("freeze_pending", int'(got.pend), 1);
        idle(1);
        chk1("freeze_late_resolve", int'({got.lpc, got.flush}), 'b11);
        idle(0);
        chk1("freeze_no_timeout", int'({got.pend, got.tmo}), 0);
        chk1("freeze_stall_cnt", int'(got.st), 8);

        // TRAP never resolving: flag appears after 8 unresolved waits and sticks.
        step(1, op_trap, 0, 0, 0, 1, 1, 0, 0);
        repeat (8) idle(0);
        chk1("timeout_not_yet", int'(got.tmo), 0);
        idle(0);
        chk1("timeout_set", int'(got.tmo), 1);
        idle(1);
        idle(0);
        chk1("timeout_sticky", int'({got.tmo, got.pend}), 'b10);

        // Asynchronous reset in the middle of a control wait.
        step(1, op_jsr, 0, 0, 0, 1, 1, 0, 0);
        idle(0);
        do_reset();
        idle(0);
        chk1("post_reset_state", int'({got.pend, got.tmo, got.lpc}), 'b001);
        chk1("post_reset_stall_cnt", int'(got.st), 0);

        // Stall counter saturates instead of wrapping.
        repeat (SMAX + 6) step(0, op_add, 0, 0, 0, 1, 0, 0, 0);
        idle(0);
        chk1("stall_cnt_saturated", int'(got.st), SMAX);

        // Randomized traffic with occasional asynchronous resets.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 299) == 0) do_reset();
            step($urandom_range(0, 3) != 0, lc3b_opcode'(4'($urandom_range(0, 15))),
                 $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1,
                 $urandom_range(0, 2) != 0, $urandom_range(0, 4) == 0,
                 $urandom_range(0, 1) == 1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
